// File: rtl/dev_bus_arbiter.sv
// Two-master arbiter for the shared processor-side device port: round-robin grant,
// latched request held for WAIT_CYCLES, one PrWe pulse per write. ARB_FIXED_PRIO_EN selects strict M0 priority.
module dev_bus_arbiter #(
  parameter int WAIT_CYCLES = 1,
  parameter int CNT_W       = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        m0_req,
  input  logic        m0_we,
  input  logic [31:0] m0_addr,
  input  logic [31:0] m0_wd,
  output logic        m0_ack,
  output logic [31:0] m0_rd,
  input  logic        m1_req,
  input  logic        m1_we,
  input  logic [31:0] m1_addr,
  input  logic [31:0] m1_wd,
  output logic        m1_ack,
  output logic [31:0] m1_rd,
  output logic [31:0] PrAddr,
  output logic [31:0] PrWD,
  output logic        PrWe,
  input  logic [31:0] PrRD,
  output logic        busy,
  output logic        owner
);

  // state  | meaning
  // IDLE   | no transaction, Pr outputs 0, requests sampled
  // ACCESS | latched request driven to bridge, counting device wait cycles
  // DONE   | one-cycle ack + read data to the owner
  typedef enum logic [1:0] {IDLE, ACCESS, DONE} arbState_t;

  localparam logic [CNT_W-1:0] WAIT_LD = CNT_W'(WAIT_CYCLES);

  arbState_t        state;
  logic             lastOwner;
  logic [CNT_W-1:0] cnt;
  logic [31:0]      addrL;
  logic [31:0]      wdL;
  logic             weL;
  logic [31:0]      rdL;
  logic             winner;
  logic             inAccess;
  logic             inDone;

`ifdef ARB_FIXED_PRIO_EN
  assign winner = ~m0_req;
`else
  // On a tie the master that did not go last wins; otherwise the lone requester.
  assign winner = (m0_req && m1_req) ? ~lastOwner : m1_req;
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      owner     <= 1'b0;
      lastOwner <= 1'b1;
      cnt       <= '0;
      addrL     <= '0;
      wdL       <= '0;
      weL       <= 1'b0;
      rdL       <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (m0_req || m1_req) begin
            owner <= winner;
            addrL <= winner ? m1_addr : m0_addr;
            wdL   <= winner ? m1_wd   : m0_wd;
            weL   <= winner ? m1_we   : m0_we;
            cnt   <= WAIT_LD;
            state <= ACCESS;
          end
        end
        ACCESS: begin
          if (cnt != '0) begin
            cnt <= cnt - CNT_W'(1);
          end else begin
            rdL   <= PrRD;
            state <= DONE;
          end
        end
        DONE: begin
          lastOwner <= owner;
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign inAccess = (state == ACCESS);
  assign inDone   = (state == DONE);

  // Outputs decode straight from registered state so an async reset clears them at once.
  assign PrAddr = inAccess ? addrL : '0;
  assign PrWD   = inAccess ? wdL   : '0;
  assign PrWe   = inAccess && (cnt == '0) && weL;
  assign busy   = (state != IDLE);
  assign m0_ack = inDone && !owner;
  assign m1_ack = inDone && owner;
  assign m0_rd  = m0_ack ? rdL : '0;
  assign m1_rd  = m1_ack ? rdL : '0;

endmodule

// File: tb/tb_dev_bus_arbiter.sv
// Self-checking bench for dev_bus_arbiter: vector table + scoreboard on a WAIT_CYCLES=2
// instance, plus a WAIT_CYCLES=0 instance for back-to-back throughput.
module tb_dev_bus_arbiter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rstN;
  logic        m0Req, m0We, m1Req, m1We;
  logic [31:0] m0Addr, m0Wd, m1Addr, m1Wd;
  logic        m0Ack, m1Ack;
  logic [31:0] m0Rd, m1Rd;
  logic [31:0] prAddr, prWd, prRd;
  logic        prWe, busy, owner;

  logic        zReq, zWe;
  logic [31:0] zAddr, zWd, zPrRd;
  logic        zAck, z1Ack;
  logic [31:0] zRd, z1Rd, zPrAddr, zPrWd;
  logic        zPrWe, zBusy, zOwner;

  dev_bus_arbiter #(.WAIT_CYCLES(2), .CNT_W(4)) dut (
    .clk(clk), .reset(rstN),
    .m0_req(m0Req), .m0_we(m0We), .m0_addr(m0Addr), .m0_wd(m0Wd), .m0_ack(m0Ack), .m0_rd(m0Rd),
    .m1_req(m1Req), .m1_we(m1We), .m1_addr(m1Addr), .m1_wd(m1Wd), .m1_ack(m1Ack), .m1_rd(m1Rd),
    .PrAddr(prAddr), .PrWD(prWd), .PrWe(prWe), .PrRD(prRd), .busy(busy), .owner(owner)
  );

  dev_bus_arbiter #(.WAIT_CYCLES(0), .CNT_W(4)) dut0 (
    .clk(clk), .reset(rstN),
    .m0_req(zReq), .m0_we(zWe), .m0_addr(zAddr), .m0_wd(zWd), .m0_ack(zAck), .m0_rd(zRd),
    .m1_req(1'b0), .m1_we(1'b0), .m1_addr(32'h0), .m1_wd(32'h0), .m1_ack(z1Ack), .m1_rd(z1Rd),
    .PrAddr(zPrAddr), .PrWD(zPrWd), .PrWe(zPrWe), .PrRD(zPrRd), .busy(zBusy), .owner(zOwner)
  );

  typedef struct {
    bit          master;
    bit          we;
    logic [31:0] addr;
    logic [31:0] wd;
    logic [31:0] rd;
  } txn_t;

  typedef struct {
    bit          master;
    bit          we;
    logic [31:0] addr;
    logic [31:0] wd;
    logic [31:0] prRd;
    logic [31:0] expRd;
    int          expLat;
  } vec_t;

  int   nCmp = 0;
  int   nBad = 0;
  int   cyc = 0;
  int   weSeen = 0;
  int   weTotal = 0;
  int   ackTotal = 0;
  int   zWeCnt = 0;
  bit   monEn = 1'b0;
  txn_t sbQ[$];
  txn_t mt;
  vec_t vecs[5];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    nCmp++;
    if (act !== exp) begin
      nBad++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  always @(negedge clk) begin
    if (prWe) weTotal++;
    if (m0Ack || m1Ack) ackTotal++;
    if (zPrWe) zWeCnt++;
    if (monEn) begin
      if (prWe) begin
        weSeen++;
        if (sbQ.size() > 0) begin
          check("we_addr", prAddr, sbQ[0].addr);
          check("we_wd", prWd, sbQ[0].wd);
        end
      end
      if (busy && !m0Ack && !m1Ack && sbQ.size() > 0) begin
        check("acc_owner", {31'h0, owner}, {31'h0, sbQ[0].master});
        check("acc_addr", prAddr, sbQ[0].addr);
      end
      if (m0Ack || m1Ack) begin
        if (sbQ.size() == 0) begin
          check("ack_unexpected", {31'h0, m1Ack}, 32'hFFFF_FFFF);
        end else begin
          mt = sbQ.pop_front();
          check("ack_master", {31'h0, m1Ack}, {31'h0, mt.master});
          check("ack_single", {31'h0, m0Ack & m1Ack}, 32'h0);
          check("ack_rd", mt.master ? m1Rd : m0Rd, mt.rd);
          check("other_rd", mt.master ? m0Rd : m1Rd, 32'h0);
          check("we_pulses", weSeen, {31'h0, mt.we});
          weSeen = 0;
        end
      end
    end
  end

  task automatic waitAck(input bit m, output int ackCyc);
    ackCyc = -1;
    for (int b = 0; b < 40; b++) begin
      @(negedge clk);
      if (m ? m1Ack : m0Ack) begin
        ackCyc = cyc;
        break;
      end
    end
    if (ackCyc < 0) check("ack_timeout", 32'h0, 32'h1);
  endtask

  task automatic pulseReset();
    @(posedge clk); #1 rstN = 1'b0;
    repeat (2) @(posedge clk);
    #1 rstN = 1'b1;
  endtask

  initial begin
    int t0, ac, n, snapWe, snapAck, accCyc;
    int ackC[3];
    bit exp6[6];
    txn_t e;

    m0Req = 0; m0We = 0; m0Addr = 0; m0Wd = 0;
    m1Req = 0; m1We = 0; m1Addr = 0; m1Wd = 0;
    prRd = 0; zReq = 0; zWe = 0; zAddr = 0; zWd = 0; zPrRd = 0;
    rstN = 1'b1;
    #1 rstN = 1'b0;

    vecs[0] = '{master: 0, we: 1, addr: 32'h0000_7F00, wd: 32'hDEAD_BEEF, prRd: 32'hAAAA_5555, expRd: 32'hAAAA_5555, expLat: 4};
    vecs[1] = '{master: 1, we: 0, addr: 32'h0000_7F04, wd: 32'h0,         prRd: 32'h1234_5678, expRd: 32'h1234_5678, expLat: 4};
    vecs[2] = '{master: 0, we: 0, addr: 32'h0000_0000, wd: 32'h0,         prRd: 32'hFFFF_FFFF, expRd: 32'hFFFF_FFFF, expLat: 4};
    vecs[3] = '{master: 1, we: 1, addr: 32'hFFFF_FFFC, wd: 32'h0000_0000, prRd: 32'h0F0F_0F0F, expRd: 32'h0F0F_0F0F, expLat: 4};
    vecs[4] = '{master: 0, we: 1, addr: 32'h8000_0000, wd: 32'h5A5A_5A5A, prRd: 32'h0,         expRd: 32'h0,         expLat: 4};

    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_busy", {31'h0, busy}, 32'h0);
    check("rst_prwe", {31'h0, prWe}, 32'h0);
    check("rst_praddr", prAddr, 32'h0);
    check("rst_acks", {30'h0, m1Ack, m0Ack}, 32'h0);
    check("rst_rd", m0Rd | m1Rd, 32'h0);
    @(posedge clk); #1 rstN = 1'b1;
    monEn = 1'b1;

    // Table-driven single transactions.
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      prRd = vecs[i].prRd;
      if (vecs[i].master) begin m1We = vecs[i].we; m1Addr = vecs[i].addr; m1Wd = vecs[i].wd; end
      else                begin m0We = vecs[i].we; m0Addr = vecs[i].addr; m0Wd = vecs[i].wd; end
      sbQ.push_back('{master: vecs[i].master, we: vecs[i].we, addr: vecs[i].addr, wd: vecs[i].wd, rd: vecs[i].expRd});
      if (vecs[i].master) m1Req = 1'b1; else m0Req = 1'b1;
      t0 = cyc;
      waitAck(vecs[i].master, ac);
      check("latency", ac - t0, vecs[i].expLat);
      @(posedge clk); #1;
      m0Req = 1'b0; m1Req = 1'b0;
    end

    // M1 arrives while M0 is in ACCESS.
    @(posedge clk); #1;
    prRd = 32'h1111_1111;
    m0We = 0; m0Addr = 32'h0000_0100; m1We = 0; m1Addr = 32'h0000_0200;
    sbQ.push_back('{master: 0, we: 0, addr: 32'h100, wd: 32'h0, rd: 32'h1111_1111});
    sbQ.push_back('{master: 1, we: 0, addr: 32'h200, wd: 32'h0, rd: 32'h2222_2222});
    m0Req = 1'b1; t0 = cyc;
    repeat (2) @(posedge clk);
    #1 m1Req = 1'b1;
    waitAck(0, ac);
    check("late_m0_lat", ac - t0, 4);
    @(posedge clk); #1;
    m0Req = 1'b0; prRd = 32'h2222_2222;
    @(negedge clk);
    check("late_idle_busy", {31'h0, busy}, 32'h0);
    check("late_idle_addr", prAddr, 32'h0);
    @(negedge clk);
    check("late_grant_owner", {30'h0, busy, owner}, 32'h3);
    check("late_grant_addr", prAddr, 32'h200);
    waitAck(1, ac);
    check("late_m1_lat", ac - t0, 9);
    @(posedge clk); #1 m1Req = 1'b0;

    // Continuous dual requests from reset.
    pulseReset();
`ifdef ARB_FIXED_PRIO_EN
    exp6 = '{0, 0, 0, 0, 0, 0};
`else
    exp6 = '{0, 1, 0, 1, 0, 1};
`endif
    prRd = 32'hC0FF_EE00;
    m0We = 0; m1We = 0; m0Addr = 32'h10; m1Addr = 32'h20;
    for (int i = 0; i < 6; i++)
      sbQ.push_back('{master: exp6[i], we: 0, addr: exp6[i] ? 32'h20 : 32'h10, wd: 32'h0, rd: 32'hC0FF_EE00});
    #1 m0Req = 1'b1; m1Req = 1'b1;
    n = 0;
    for (int b = 0; b < 100 && n < 6; b++) begin
      @(negedge clk);
      if (m0Ack || m1Ack) n++;
    end
    check("rr_count", n, 6);
    @(posedge clk); #1;
    m0Req = 1'b0; m1Req = 1'b0;
    check("rr_sb_empty", sbQ.size(), 0);

    // Reset during a counting write: no pulse, no ack, outputs cleared at once.
    repeat (2) @(posedge clk);
    monEn = 1'b0;
    snapWe = weTotal; snapAck = ackTotal;
    #1;
    m0We = 1; m0Addr = 32'h0000_7F08; m0Wd = 32'h0BAD_F00D;
    m0Req = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("mid_in_access", {31'h0, busy}, 32'h1);
    check("mid_praddr_pre", prAddr, 32'h0000_7F08);
    rstN = 1'b0;
    #1;
    check("mid_busy", {31'h0, busy}, 32'h0);
    check("mid_praddr", prAddr, 32'h0);
    check("mid_prwd", prWd, 32'h0);
    m0Req = 1'b0;
    repeat (2) @(posedge clk);
    #1 rstN = 1'b1;
    repeat (10) @(negedge clk);
    check("mid_no_prwe", weTotal - snapWe, 0);
    check("mid_no_ack", ackTotal - snapAck, 0);

    // First tie after reset goes to M0.
    monEn = 1'b1;
    @(posedge clk); #1;
    prRd = 32'h3333_3333;
    m0We = 0; m1We = 0; m0Addr = 32'h30; m1Addr = 32'h40;
    e = '{master: 0, we: 0, addr: 32'h30, wd: 32'h0, rd: 32'h3333_3333};
    sbQ.push_back(e);
    e.master = 1; e.addr = 32'h40;
    sbQ.push_back(e);
    m0Req = 1'b1; m1Req = 1'b1;
    waitAck(0, ac);
    @(posedge clk); #1 m0Req = 1'b0;
    waitAck(1, ac);
    @(posedge clk); #1 m1Req = 1'b0;
    check("tie_sb_empty", sbQ.size(), 0);

    // WAIT_CYCLES=0: back-to-back writes every 3 cycles.
    @(posedge clk); #1;
    zWe = 1; zAddr = 32'h44; zWd = 32'h55; zPrRd = 32'h99;
    snapWe = zWeCnt; accCyc = 0; n = 0;
    zReq = 1'b1; t0 = cyc;
    for (int b = 0; b < 30 && n < 3; b++) begin
      @(negedge clk);
      if (zBusy && !zAck) accCyc++;
      if (zPrWe) check("z_we_addr", zPrAddr, 32'h44);
      if (zAck) begin
        if (n == 0) check("z_rd", zRd, 32'h99);
        ackC[n] = cyc;
        n++;
      end
    end
    @(posedge clk); #1 zReq = 1'b0;
    check("z_count", n, 3);
    for (int i = 0; i < 3; i++) check("z_ack_cycle", ackC[i] - t0, 2 + 3 * i);
    check("z_access_cycles", accCyc, 3);
    check("z_we_pulses", zWeCnt - snapWe, 3);
    check("z_no_m1_ack", {31'h0, z1Ack}, 32'h0);

    repeat (3) @(posedge clk);
    check("sb_final_empty", sbQ.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nBad);
    $finish;
  end

endmodule

// File: doc/dev_bus_arbiter.md
Name: dev_bus_arbiter

Overview:
- Shares the single processor-side device port (PrAddr/PrWD/PrWe/PrRD into the device bridge) between two requesters: M0 (CPU data port) and M1 (DMA/debug master).
- Arbitrates round-robin, latches the winning request and holds it stable for a programmable number of device wait cycles.
- Issues exactly one PrWe pulse per write and returns read data with a one-cycle ack.
- Sits between the masters and the bridge; performs no address decode.

Parameters:
- WAIT_CYCLES, 1, extra cycles the device needs before PrRD is valid / write commits (0..15).
- CNT_W, 4, width of the wait counter; must hold WAIT_CYCLES.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- m0_req  in  1  M0 access request; held high until m0_ack.
- m0_we  in  1  M0 write enable (1=write, 0=read).
- m0_addr  in  32  M0 byte address.
- m0_wd  in  32  M0 write data.
- m0_ack  out  1  one-cycle completion strobe to M0.
- m0_rd  out  32  M0 read data, valid while m0_ack=1.
- m1_req, m1_we, m1_addr, m1_wd, m1_ack, m1_rd: same as M0, for M1.
- PrAddr  out  32  address to bridge.
- PrWD  out  32  write data to bridge.
- PrWe  out  1  write strobe to bridge.
- PrRD  in  32  read data from bridge.
- busy  out  1  high in ACCESS or DONE.
- owner  out  1  index of the granted master; valid while busy.

Behaviour:
- States: IDLE, ACCESS, DONE. Registers: state, owner, last_owner, cnt, addr_l, wd_l, we_l, rd_l.
- Reset (reset=0, asynchronous): state=IDLE, last_owner=1 (M0 wins first tie), cnt=0, all latches=0.
  - All outputs go to 0 immediately, including PrWe, both acks and both rd buses.
- IDLE:
  - Pr outputs are 0.
  - One req high: grant that master.
  - Both high: grant the master != last_owner. With ARB_FIXED_PRIO_EN, M0 always wins.
  - On grant: latch addr/wd/we, owner<=winner, cnt<=WAIT_CYCLES, next state ACCESS.
  - No req: stay in IDLE.
- ACCESS:
  - PrAddr=addr_l and PrWD=wd_l, stable for the whole state.
  - cnt>0: cnt<=cnt-1 each cycle.
  - cnt==0: PrWe=we_l (combinational, this cycle only), rd_l<=PrRD, next state DONE.
  - ACCESS lasts WAIT_CYCLES+1 cycles. PrWe is high on exactly one cycle per write and never on reads.
- DONE:
  - m{owner}_ack=1 and m{owner}_rd=rd_l; the other master's ack=0 and rd=0.
  - last_owner<=owner, next state IDLE.
  - For writes, rd_l holds whatever PrRD showed; masters ignore it.
- Master contract:
  - A master samples ack at the clock edge ending DONE and drops req, or presents a new request, from that edge onward.
  - The arbiter re-samples req in the following IDLE cycle, so there is no duplicate issue.
  - Master signals must be stable while req=1. The arbiter reads them only in IDLE.
- Latency: req first high in IDLE cycle t gives ack in cycle t+WAIT_CYCLES+2.
  - Throughput: one transaction per WAIT_CYCLES+3 cycles.
- Simultaneous events: a request arriving during ACCESS/DONE waits; nothing is dropped.
- Fairness: under continuous dual requests, grants alternate M0,M1,M0,...
- Reset mid-operation: transaction aborted, no ack.
  - A write whose PrWe already pulsed stays committed. A write still counting never pulses PrWe.
- Widths: addresses and data pass through unmodified. cnt never wraps (loaded only in IDLE).

Optional Feature:
- ARB_FIXED_PRIO_EN defined: strict priority, M0 wins every tie; last_owner is still updated but ignored.
- Undefined: round-robin as above.

Test Plan:
- WAIT_CYCLES=2, M0 write addr 0x0000_7F00, wd 0xDEAD_BEEF -> PrWe high for exactly 1 cycle with those values on PrAddr/PrWD; m0_ack 4 cycles after req; M1 sees no ack.
- M1 read addr 0x0000_7F04, bench drives PrRD=0x1234_5678 -> m1_ack for 1 cycle with m1_rd=0x1234_5678; PrWe stays 0 throughout.
- Both req continuously from reset, 6 transactions -> grant order M0,M1,M0,M1,M0,M1; with ARB_FIXED_PRIO_EN, M0 x6 and M1 starved.
- WAIT_CYCLES=0 -> ACCESS lasts 1 cycle; ack 2 cycles after req; back-to-back M0 requests complete every 3 cycles.
- Assert reset low during ACCESS with cnt=1 on a write -> outputs zero at once; PrWe never pulses; no ack; after release state=IDLE and next tie goes to M0.
- M1 req raised during M0 ACCESS -> M1 is granted in the IDLE cycle right after M0's DONE; its PrAddr changes only after that grant.
